hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Resolves memory stalls, taken-branch flushes, load-use bubbles and the
// HLT drain/halt sequence. Stage enables and flushes are combinational from
// the current state and inputs. Stall and flush events are counted in
// saturating performance counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_valid,
  input  logic [3:0]  id_op,
  input  logic [3:0]  ex_rd,
  input  logic [3:0]  ex_op,
  input  logic        ex_valid,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] mem_stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] drain_cnt_r;
  logic [1:0] drain_nxt_s;
  logic       br_pend_r;
  logic       br_pend_nxt_s;
  logic       lu_s;
  logic       hlt_s;
  logic       lu_fire_s;
  logic       br_fire_s;
  logic       mem_stall_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Load-use detection; register 0 is constant so it never creates a hazard.
  always_comb begin
    lu_s  = ex_valid && (ex_op == OP_LW) && (ex_rd != 4'd0) && id_valid &&
            ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    hlt_s = id_valid && (id_op == OP_HLT);
  end

  // Prioritised hazard resolution: enables, flushes and next-state values.
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    state_nxt_s   = state_r;
    drain_nxt_s   = drain_cnt_r;
    br_pend_nxt_s = br_pend_r;
    lu_fire_s     = 1'b0;
    br_fire_s     = 1'b0;
    mem_stall_s   = 1'b0;
    case (state_r)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          // EX is frozen: remember a taken branch so it is acted on later.
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          mem_stall_s   = 1'b1;
          br_pend_nxt_s = br_pend_r | br_taken;
          state_nxt_s   = MEM_WAIT;
        end else if (br_taken || br_pend_r) begin
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          br_fire_s     = 1'b1;
          br_pend_nxt_s = 1'b0;
          state_nxt_s   = RUN;
        end else if (lu_s) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          lu_fire_s   = 1'b1;
          state_nxt_s = RUN;
        end else if (hlt_s) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          drain_nxt_s = 2'd2;
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        // Older instructions drain out while bubbles enter EX.
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        if (mem_busy) begin
          id_ex_we    = 1'b0;
          mem_stall_s = 1'b1;
        end else if (drain_cnt_r == 2'd0) begin
          state_nxt_s = HALTED;
        end else begin
          drain_nxt_s = drain_cnt_r - 2'd1;
        end
      end
      HALTED: begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        id_ex_we = 1'b0;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Halted flag follows the state register so reset clears it at once.
  always_comb begin
    halted = (state_r == HALTED);
  end

  // State, drain counter, pending branch and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= RUN;
      drain_cnt_r   <= 2'd0;
      br_pend_r     <= 1'b0;
      lu_stall_cnt  <= 16'd0;
      mem_stall_cnt <= 16'd0;
      flush_cnt     <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_nxt_s;
      br_pend_r   <= br_pend_nxt_s;
      if (lu_fire_s) begin
        lu_stall_cnt <= sat_inc(lu_stall_cnt);
      end
      if (mem_stall_s) begin
        mem_stall_cnt <= sat_inc(mem_stall_cnt);
      end
      if (br_fire_s) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [3:0]  ex_rd;
  logic [3:0]  ex_op;
  logic        ex_valid;
  logic        br_taken;
  logic        mem_busy;
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        halted;
  logic [15:0] lu_stall_cnt;
  logic [15:0] mem_stall_cnt;
  logic [15:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_valid     (id_valid),
    .id_op        (id_op),
    .ex_rd        (ex_rd),
    .ex_op        (ex_op),
    .ex_valid     (ex_valid),
    .br_taken     (br_taken),
    .mem_busy     (mem_busy),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .halted       (halted),
    .lu_stall_cnt (lu_stall_cnt),
    .mem_stall_cnt(mem_stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected order: {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, halted}
  task automatic chk_o(input string tag, input logic [5:0] exp);
    chk(tag, {10'd0, pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, halted},
        {10'd0, exp});
  endtask

  task automatic chk_c(input string tag, input logic [15:0] lu,
                       input logic [15:0] ms, input logic [15:0] fl);
    chk({tag, "_lu"}, lu_stall_cnt, lu);
    chk({tag, "_mem"}, mem_stall_cnt, ms);
    chk({tag, "_flush"}, flush_cnt, fl);
  endtask

  task automatic idle();
    id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_valid = 1'b0; id_op = 4'd0; ex_rd = 4'd0; ex_op = 4'd0;
    ex_valid = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2;
    chk_o("reset_out", 6'b111000);
    chk_c("reset", 16'd0, 16'd0, 16'd0);
    tick();
    rst = 1'b1;
    tick();

    // r0 exception: load to r0 never stalls
    ex_valid = 1'b1; ex_op = 4'b1000; ex_rd = 4'd0;
    id_valid = 1'b1; id_rs = 4'd0; id_uses_rs = 1'b1;
    #1 chk_o("r0_out", 6'b111000);
    tick();
    chk("r0_lu_cnt", lu_stall_cnt, 16'd0);

    // load-use on rs
    ex_rd = 4'd3; id_rs = 4'd3;
    #1 chk_o("lu_out", 6'b001010);
    tick();
    chk("lu_cnt", lu_stall_cnt, 16'd1);
    ex_valid = 1'b0;
    #1 chk_o("lu_bubble_out", 6'b111000);
    tick();

    // load-use on rt
    idle();
    ex_valid = 1'b1; ex_op = 4'b1000; ex_rd = 4'd7;
    id_valid = 1'b1; id_rt = 4'd7; id_uses_rt = 1'b1;
    #1 chk_o("lu_rt_out", 6'b001010);
    tick();
    chk("lu_rt_cnt", lu_stall_cnt, 16'd2);

    // branch held under a 4-cycle memory stall
    idle();
    br_taken = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_o("memstall_out", 6'b000000);
      tick();
    end
    chk("memstall_cnt", mem_stall_cnt, 16'd4);
    chk("memstall_flush_cnt", flush_cnt, 16'd0);
    mem_busy = 1'b0;
    #1 chk_o("br_after_stall_out", 6'b111110);
    tick();
    chk("br_after_stall_flush_cnt", flush_cnt, 16'd1);
    br_taken = 1'b0;
    #1 chk_o("after_br_out", 6'b111000);
    tick();

    // priority: branch wins over load-use
    ex_valid = 1'b1; ex_op = 4'b1000; ex_rd = 4'd5;
    id_valid = 1'b1; id_rs = 4'd5; id_uses_rs = 1'b1; br_taken = 1'b1;
    #1 chk_o("prio_out", 6'b111110);
    tick();
    chk_c("prio", 16'd2, 16'd4, 16'd2);

    // halt: HLT accepted, drain with one stalled cycle, then halted
    idle();
    id_valid = 1'b1; id_op = 4'b1111;
    #1 chk_o("hlt_out", 6'b001010);
    tick();
    idle();
    #1 chk_o("drain1_out", 6'b001010);
    tick();
    mem_busy = 1'b1;
    #1 chk_o("drain_busy_out", 6'b000010);
    tick();
    chk("drain_busy_mem_cnt", mem_stall_cnt, 16'd5);
    mem_busy = 1'b0; br_taken = 1'b1;
    #1 chk_o("drain2_out", 6'b001010);
    tick();
    chk("drain2_flush_cnt", flush_cnt, 16'd2);
    br_taken = 1'b0;
    #1 chk_o("drain3_out", 6'b001010);
    tick();
    for (int i = 0; i < 10; i++) begin
      mem_busy = (i == 3);
      br_taken = (i == 5);
      #1 chk_o("halted_out", 6'b000001);
      tick();
    end
    chk_c("halted", 16'd2, 16'd5, 16'd2);

    // reset leaves HALTED
    idle();
    #1 rst = 1'b0;
    #1 chk_o("rst_halt_out", 6'b111000);
    chk_c("rst_halt", 16'd0, 16'd0, 16'd0);
    rst = 1'b1;
    tick();

    // reset asserted mid-DRAIN
    ex_valid = 1'b1; ex_op = 4'b1000; ex_rd = 4'd2;
    id_valid = 1'b1; id_rt = 4'd2; id_uses_rt = 1'b1;
    #1 chk_o("lu2_out", 6'b001010);
    tick();
    idle();
    id_valid = 1'b1; id_op = 4'b1111;
    tick();
    idle();
    #1 chk_o("pre_rst_drain_out", 6'b001010);
    chk("pre_rst_lu_cnt", lu_stall_cnt, 16'd1);
    #1 rst = 1'b0;
    #1 chk_o("rst_drain_out", 6'b111000);
    chk_c("rst_drain", 16'd0, 16'd0, 16'd0);
    #1 rst = 1'b1;
    tick();
    #1 chk_o("post_rst_out", 6'b111000);
    tick();
    ex_valid = 1'b1; ex_op = 4'b1000; ex_rd = 4'd9;
    id_valid = 1'b1; id_rs = 4'd9; id_uses_rs = 1'b1;
    #1 chk_o("post_rst_lu_out", 6'b001010);
    tick();
    chk("post_rst_lu_cnt", lu_stall_cnt, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
